dec2stch_array: RTL

- Multi-channel, parametrised decimal-to-stochastic converter.
- Latches NC probabilities of ND bits each and emits NC stochastic bit-streams of a programmable length.
- Each stream is framed by a valid strobe and a completion pulse.
- Contains its own maximal-length LFSR, with a per-channel bit rotation for decorrelation, and a run/done controller so upstream logic can issue back-to-back streams.

---
 rtl/dec2stch_array_if.sv | 17 +
 rtl/dec2stch_array.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dec2stch_array_if.sv
// Request/stream bundle between an upstream controller and dec2stch_array.
interface dec2stch_array_if #(
    parameter int NC = 2,
    parameter int ND = 8,
    parameter int LW = 10
);
    logic             START;
    logic [LW-1:0]    LEN;
    logic [NC*ND-1:0] D;
    logic             READY;
    logic [NC-1:0]    S;
    logic             SV;
    logic             DONE;

    modport master (output START, LEN, D, input READY, S, SV, DONE);
    modport slave  (input START, LEN, D, output READY, S, SV, DONE);
endinterface

// File: rtl/dec2stch_array.sv
// Multi-channel decimal-to-stochastic converter: one shared Galois LFSR, rotated per
// channel, compared against latched probabilities to emit framed bit-streams.
module dec2stch_array #(
    parameter int            NC     = 2,
    parameter int            ND     = 8,
    parameter int            LW     = 10,
    parameter logic [ND-1:0] TAPS   = 8'hB8,
    parameter logic [ND-1:0] SEED   = 8'h01,
    parameter int            ROT    = 3,
    parameter bit            RESEED = 1'b1
) (
    input logic             CLK,
    input logic             INIT,
    dec2stch_array_if.slave bus
);

    localparam logic [ND-1:0] SEED_EFF = (SEED == '0) ? ND'(1) : SEED;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic logic [ND-1:0] galois_step(input logic [ND-1:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    function automatic logic [ND-1:0] rotl(input logic [ND-1:0] v, input int n);
        logic [2*ND-1:0] t;
        t = {v, v} << n;
        return t[2*ND-1:ND];
    endfunction

    state_t           state_q;
    state_t           state_nx;
    logic             accept;
    logic             emit;
    logic [ND-1:0]    lfsr_p0;
    logic [LW-1:0]    cnt_p0;
    logic [NC*ND-1:0] dlat_p0;
    logic [ND-1:0]    src_lfsr;
    logic [NC*ND-1:0] src_d;
    logic [NC-1:0]    bit_nx;
    logic [NC-1:0]    s_p1;
    logic             sv_p1;

    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    // The first bit is produced on the accepting edge, so a START taken in the
    // DONE cycle continues the valid window without a gap.
    always_comb begin
        state_nx = state_q;
        accept   = 1'b0;
        emit     = 1'b0;
        case (state_q)
            ST_RUN: begin
                emit = 1'b1;
                if (cnt_p0 == LW'(1)) begin
                    state_nx = ST_DONE;
                end
            end
            default: begin
                if (bus.START) begin
                    accept   = 1'b1;
                    emit     = (bus.LEN != '0);
                    state_nx = (bus.LEN > LW'(1)) ? ST_RUN : ST_DONE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        src_lfsr = (accept && RESEED) ? SEED_EFF : lfsr_p0;
        src_d    = accept ? bus.D : dlat_p0;
        bit_nx   = '0;
        for (int c = 0; c < NC; c++) begin
            bit_nx[c] = (src_d[c*ND +: ND] >= rotl(src_lfsr, (c * ROT) % ND));
        end
    end

    // p0: latched request and generator state / p1: registered stream outputs
    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            lfsr_p0 <= SEED_EFF;
            cnt_p0  <= '0;
            dlat_p0 <= '0;
            s_p1    <= '0;
            sv_p1   <= 1'b0;
        end else begin
            if (accept) begin
                dlat_p0 <= bus.D;
                cnt_p0  <= (bus.LEN == '0) ? '0 : (bus.LEN - LW'(1));
            end else if (emit) begin
                cnt_p0 <= cnt_p0 - LW'(1);
            end
            if (emit) begin
                lfsr_p0 <= galois_step(src_lfsr);
            end else if (accept) begin
                lfsr_p0 <= src_lfsr;
            end
            s_p1  <= emit ? bit_nx : '0;
            sv_p1 <= emit;
        end
    end

    assign bus.READY = (state_q != ST_RUN);
    assign bus.DONE  = (state_q == ST_DONE);
    assign bus.S     = s_p1;
    assign bus.SV    = sv_p1;

endmodule
